// File: rtl/register_file_pkg.sv
// rtl/register_file_pkg.sv - shared core sizing: data width, register count, register-index type
package register_file_pkg;

    localparam int CORE_XLEN = 32;
    localparam int CORE_NREG = 32;
    localparam int REG_IDX_W = $clog2(CORE_NREG);

    typedef logic [REG_IDX_W-1:0] reg_idx_t;

endpackage

// File: rtl/register_file.sv
// rtl/register_file.sv - flop-based register file, two bypassed decode read ports plus a raw debug port
module register_file
    import register_file_pkg::*;
#(
    parameter int XLEN = CORE_XLEN,
    parameter int NREG = CORE_NREG
) (
    input  logic            clk,
    input  logic            reset,
    input  logic            RegWriteW2F,
    input  reg_idx_t        rdW2F,
    input  logic [XLEN-1:0] ResultW2F,
    input  reg_idx_t        rs1D,
    input  reg_idx_t        rs2D,
    output logic [XLEN-1:0] RD1D,
    output logic [XLEN-1:0] RD2D,
    input  reg_idx_t        dbg_addr,
    output logic [XLEN-1:0] dbg_data,
    output logic [NREG-1:0] written_mask,
    output logic [31:0]     wr_count
);

    logic [XLEN-1:0] regs [NREG];
    logic [NREG-1:0] written_mask_q;
    logic [31:0]     wr_count_q;
    logic            write_live;
    logic            commit;

    // A write pending in the same cycle as reset is discarded, so it must not bypass either.
    function automatic logic bypass_hit(input logic live, input reg_idx_t wa, input reg_idx_t ra);
        return live && (wa != '0) && (wa == ra);
    endfunction

    assign write_live = RegWriteW2F && !reset;
    assign commit     = write_live && (rdW2F != '0);

    always_ff @(posedge clk) begin
        if (reset) begin
            for (int i = 0; i < NREG; i++) begin
                regs[i] <= '0;
            end
            written_mask_q <= '0;
            wr_count_q     <= '0;
        end else if (commit) begin
            regs[rdW2F]           <= ResultW2F;
            written_mask_q[rdW2F] <= 1'b1;
            wr_count_q            <= wr_count_q + 32'd1;
        end
    end

    // x0 is never written, so plain array reads already return 0 for address 0.
    always_comb begin
        RD1D     = regs[rs1D];
        RD2D     = regs[rs2D];
        dbg_data = regs[dbg_addr];
        if (bypass_hit(write_live, rdW2F, rs1D)) begin
            RD1D = ResultW2F;
        end
        if (bypass_hit(write_live, rdW2F, rs2D)) begin
            RD2D = ResultW2F;
        end
    end

    assign written_mask = written_mask_q;
    assign wr_count     = wr_count_q;

endmodule
